// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - Moore sequencer for a shift-add multiplier datapath
module mul_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             ctrl_clk,
    input  logic             ctrl_rst,
    input  logic             start,
    input  logic             mult_lsb,
    output logic             ld_a_en,
    output logic             ld_b_en,
    output logic             acc_clr,
    output logic             acc_add,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Counter value seen during the SHIFT of the final iteration.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    // State and iteration counter registers; reset aborts any operation in flight.
    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state and counter update; start is only looked at in IDLE, mult_lsb only in TEST.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                iter_d  = '0;
                state_d = S_TEST;
            end
            S_TEST: begin
                state_d = mult_lsb ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                iter_d  = iter_q + CNT_W'(1);
                state_d = (iter_q == LAST_ITER) ? S_DONE : S_TEST;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        ld_a_en  = 1'b0;
        ld_b_en  = 1'b0;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_LOAD: begin
                ld_a_en = 1'b1;
                ld_b_en = 1'b1;
                acc_clr = 1'b1;
                busy    = 1'b1;
            end
            S_TEST: begin
                busy = 1'b1;
            end
            S_ADD: begin
                acc_add = 1'b1;
                busy    = 1'b1;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign iter_cnt = iter_q;

endmodule
